// File: rtl/lcd_ctrl_gen2.sv
// Purpose : image-window processor; loads an IMG_W x IMG_W image from IROM, applies
//           window commands around the operation point, writes the image out to IRAM.
// Latency : load ~IMG_W*IMG_W+2 cycles after reset; non-write cmds 1 cycle; write IMG_W*IMG_W+1 cycles.
// Backpressure: busy=1 while loading/executing/writing; cmd_valid is ignored while busy.
//
// Ports:
//   clk, reset                 single clock, synchronous active-high reset
//   cmd[3:0], cmd_valid        command input, sampled only when busy=0
//   IROM_rd, IROM_A, IROM_Q    image ROM read port (data returns two edges after issue)
//   IRAM_valid, IRAM_A, IRAM_D result RAM write port
//   busy, done                 status; done pulses once after the last IRAM write
// Build option: define LCD_CTRL_MEDIAN_EN to enable cmd C (median of the window).
module lcd_ctrl_gen2 #(
   parameter int IMG_W  = 8,
   parameter int DATA_W = 8,
   localparam int AW    = 2 * $clog2(IMG_W)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [3:0]        cmd,
   input  logic              cmd_valid,
   output logic              IROM_rd,
   output logic [AW-1:0]     IROM_A,
   input  logic [DATA_W-1:0] IROM_Q,
   output logic              IRAM_valid,
   output logic [DATA_W-1:0] IRAM_D,
   output logic [AW-1:0]     IRAM_A,
   output logic              busy,
   output logic              done
);

   localparam int CW                = AW / 2;
   localparam int NPIX              = IMG_W * IMG_W;
   localparam int SW                = DATA_W + 2;
   localparam logic [AW-1:0] LAST_A = '1;
   localparam logic [AW-1:0] ONE_A  = AW'(1);
   localparam logic [CW-1:0] ONE_C  = CW'(1);
   localparam logic [CW-1:0] MAX_C  = '1;
   localparam logic [CW-1:0] CTR_C  = CW'(IMG_W / 2);

   typedef enum logic [2:0] {S_LOAD, S_IDLE, S_EXEC, S_WRITE, S_DONE} state_t;

   state_t            state;
   logic [DATA_W-1:0] pix_mem [NPIX];
   logic [CW-1:0]     op_x, op_y;
   logic [3:0]        cmd_r;
   logic              pipe_vld;     // ROM read issued one edge ago; its data lands next edge
   logic [AW-1:0]     pipe_a;
   logic              issued_all;

   // window addresses: row-major, so address = {y, x}
   logic [CW-1:0]     xm1, ym1;
   logic [AW-1:0]     a_tl, a_tr, a_bl, a_br;
   logic [DATA_W-1:0] p_tl, p_tr, p_bl, p_br;
   logic [DATA_W-1:0] n_tl, n_tr, n_bl, n_br;
   logic [DATA_W-1:0] max_top, max_bot, pmax, min_top, min_bot, pmin;
   logic [SW-1:0]     sum;

   assign xm1  = op_x - ONE_C;
   assign ym1  = op_y - ONE_C;
   assign a_tl = {ym1, xm1};
   assign a_tr = {ym1, op_x};
   assign a_bl = {op_y, xm1};
   assign a_br = {op_y, op_x};
   assign p_tl = pix_mem[a_tl];
   assign p_tr = pix_mem[a_tr];
   assign p_bl = pix_mem[a_bl];
   assign p_br = pix_mem[a_br];

   always_comb begin
      max_top = (p_tl > p_tr) ? p_tl : p_tr;
      max_bot = (p_bl > p_br) ? p_bl : p_br;
      pmax    = (max_top > max_bot) ? max_top : max_bot;
      min_top = (p_tl < p_tr) ? p_tl : p_tr;
      min_bot = (p_bl < p_br) ? p_bl : p_br;
      pmin    = (min_top < min_bot) ? min_top : min_bot;
      sum     = SW'(p_tl) + SW'(p_tr) + SW'(p_bl) + SW'(p_br);
   end

   // new window contents for the latched command; unchanged for non-pixel commands
   always_comb begin
      n_tl = p_tl;
      n_tr = p_tr;
      n_bl = p_bl;
      n_br = p_br;
      case (cmd_r)
         4'h5: begin n_tl = pmax; n_tr = pmax; n_bl = pmax; n_br = pmax; end
         4'h6: begin n_tl = pmin; n_tr = pmin; n_bl = pmin; n_br = pmin; end
         4'h7: begin
            n_tl = DATA_W'(sum >> 2);
            n_tr = DATA_W'(sum >> 2);
            n_bl = DATA_W'(sum >> 2);
            n_br = DATA_W'(sum >> 2);
         end
         4'h8: begin n_tl = p_tr; n_tr = p_br; n_br = p_bl; n_bl = p_tl; end
         4'h9: begin n_tl = p_bl; n_bl = p_br; n_br = p_tr; n_tr = p_tl; end
         4'hA: begin n_tl = p_bl; n_bl = p_tl; n_tr = p_br; n_br = p_tr; end
         4'hB: begin n_tl = p_tr; n_tr = p_tl; n_bl = p_br; n_br = p_bl; end
`ifdef LCD_CTRL_MEDIAN_EN
         // the two middle values of four add up to sum - max - min
         4'hC: begin
            n_tl = DATA_W'((sum - SW'(pmax) - SW'(pmin)) >> 1);
            n_tr = DATA_W'((sum - SW'(pmax) - SW'(pmin)) >> 1);
            n_bl = DATA_W'((sum - SW'(pmax) - SW'(pmin)) >> 1);
            n_br = DATA_W'((sum - SW'(pmax) - SW'(pmin)) >> 1);
         end
`endif
         default: ;
      endcase
   end

   // image buffer: filled from ROM during load, window rewritten in EXEC
   always_ff @(posedge clk) begin
      if (!reset) begin
         if (state == S_LOAD && pipe_vld) begin
            pix_mem[pipe_a] <= IROM_Q;
         end else if (state == S_EXEC) begin
            pix_mem[a_tl] <= n_tl;
            pix_mem[a_tr] <= n_tr;
            pix_mem[a_bl] <= n_bl;
            pix_mem[a_br] <= n_br;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= S_LOAD;
         busy       <= 1'b1;
         done       <= 1'b0;
         IROM_rd    <= 1'b0;
         IROM_A     <= '0;
         IRAM_valid <= 1'b0;
         IRAM_A     <= '0;
         IRAM_D     <= '0;
         op_x       <= CTR_C;
         op_y       <= CTR_C;
         cmd_r      <= '0;
         pipe_vld   <= 1'b0;
         pipe_a     <= '0;
         issued_all <= 1'b0;
      end else begin
         pipe_vld <= IROM_rd;
         pipe_a   <= IROM_A;
         case (state)
            S_LOAD: begin
               if (IROM_rd) begin
                  if (IROM_A == LAST_A) begin
                     IROM_rd    <= 1'b0;
                     issued_all <= 1'b1;
                  end else begin
                     IROM_A <= IROM_A + ONE_A;
                  end
               end else if (!issued_all) begin
                  IROM_rd <= 1'b1;
               end
               if (pipe_vld && pipe_a == LAST_A) begin
                  state <= S_IDLE;
                  busy  <= 1'b0;
               end
            end
            S_IDLE: begin
               if (cmd_valid) begin
                  busy  <= 1'b1;
                  cmd_r <= cmd;
                  if (cmd == 4'h0) begin
                     state      <= S_WRITE;
                     IRAM_valid <= 1'b1;
                     IRAM_A     <= '0;
                     IRAM_D     <= pix_mem[0];
                  end else begin
                     state <= S_EXEC;
                  end
               end
            end
            S_EXEC: begin
               case (cmd_r)
                  4'h1: if (op_y > ONE_C) op_y <= op_y - ONE_C;
                  4'h2: if (op_y != MAX_C) op_y <= op_y + ONE_C;
                  4'h3: if (op_x > ONE_C) op_x <= op_x - ONE_C;
                  4'h4: if (op_x != MAX_C) op_x <= op_x + ONE_C;
                  default: ;
               endcase
               busy  <= 1'b0;
               state <= S_IDLE;
            end
            S_WRITE: begin
               if (IRAM_A == LAST_A) begin
                  IRAM_valid <= 1'b0;
                  done       <= 1'b1;
                  state      <= S_DONE;
               end else begin
                  IRAM_A <= IRAM_A + ONE_A;
                  IRAM_D <= pix_mem[IRAM_A + ONE_A];
               end
            end
            S_DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= S_IDLE;
            end
            default: state <= S_LOAD;
         endcase
      end
   end

endmodule

// File: tb/tb_lcd_ctrl_gen2.sv
// Purpose : scoreboard bench for lcd_ctrl_gen2; an image model predicts every IRAM write.
// Latency : n/a (bench).
// Backpressure: commands are only issued while busy=0; random cmd_valid is driven while busy.
module tb_lcd_ctrl_gen2;
   parameter int IMG_W = 8;
   localparam int DATA_W = 8;
   localparam int AW     = 2 * $clog2(IMG_W);
   localparam int NPIX   = IMG_W * IMG_W;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic [3:0]        cmd = '0;
   logic              cmd_valid = 1'b0;
   logic              IROM_rd;
   logic [AW-1:0]     IROM_A;
   logic [DATA_W-1:0] IROM_Q;
   logic              IRAM_valid;
   logic [DATA_W-1:0] IRAM_D;
   logic [AW-1:0]     IRAM_A;
   logic              busy;
   logic              done;

   lcd_ctrl_gen2 #(.IMG_W(IMG_W), .DATA_W(DATA_W)) dut (
      .clk(clk), .reset(reset), .cmd(cmd), .cmd_valid(cmd_valid),
      .IROM_rd(IROM_rd), .IROM_A(IROM_A), .IROM_Q(IROM_Q),
      .IRAM_valid(IRAM_valid), .IRAM_D(IRAM_D), .IRAM_A(IRAM_A),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   // image ROM with one register stage: data for an address is sampled two edges after issue
   logic [DATA_W-1:0] rom [NPIX];
   always @(posedge clk) if (IROM_rd) IROM_Q <= rom[IROM_A];

   int compared = 0;
   int mismatched = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      bit is_done;
      int addr;
      int data;
   } exp_t;
   exp_t sb[$];

   int img [NPIX];
   int mx, my;

   function automatic int pidx(input int x, input int y);
      return y * IMG_W + x;
   endfunction

   task automatic model_reset();
      for (int a = 0; a < NPIX; a++) img[a] = int'(rom[a]);
      mx = IMG_W / 2;
      my = IMG_W / 2;
   endtask

   task automatic model_cmd(input int c);
      int idx [4];
      int t [4];
      int s [4];
      int n [4];
      int tmp;
      idx = '{pidx(mx-1, my-1), pidx(mx, my-1), pidx(mx-1, my), pidx(mx, my)}; // TL TR BL BR
      for (int i = 0; i < 4; i++) begin
         t[i] = img[idx[i]];
         s[i] = t[i];
         n[i] = t[i];
      end
      for (int i = 0; i < 3; i++)
         for (int j = 0; j < 3 - i; j++)
            if (s[j] > s[j+1]) begin tmp = s[j]; s[j] = s[j+1]; s[j+1] = tmp; end
      case (c)
         1: if (my - 1 >= 1) my--;
         2: if (my + 1 <= IMG_W - 1) my++;
         3: if (mx - 1 >= 1) mx--;
         4: if (mx + 1 <= IMG_W - 1) mx++;
         5: n = '{s[3], s[3], s[3], s[3]};
         6: n = '{s[0], s[0], s[0], s[0]};
         7: begin tmp = (t[0] + t[1] + t[2] + t[3]) / 4; n = '{tmp, tmp, tmp, tmp}; end
         8: n = '{t[1], t[3], t[0], t[2]};
         9: n = '{t[2], t[0], t[3], t[1]};
         10: n = '{t[2], t[3], t[0], t[1]};
         11: n = '{t[1], t[0], t[3], t[2]};
`ifdef LCD_CTRL_MEDIAN_EN
         12: begin tmp = (s[1] + s[2]) / 2; n = '{tmp, tmp, tmp, tmp}; end
`endif
         default: ;
      endcase
      for (int i = 0; i < 4; i++) img[idx[i]] = n[i];
   endtask

   // ---------------- monitor ----------------
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (IRAM_valid === 1'b1) begin
            if (sb.size() == 0 || sb[0].is_done) begin
               check("iram_unexpected", IRAM_valid, 0);
            end else begin
               e = sb.pop_front();
               check("iram_addr", IRAM_A, e.addr);
               check("iram_data", IRAM_D, e.data);
            end
         end
         if (done === 1'b1) begin
            if (sb.size() > 0 && sb[0].is_done) begin
               e = sb.pop_front();
               check("done_busy", busy, 1);
            end else begin
               check("done_unexpected", done, 0);
            end
         end
      end
   end

   // ---------------- driver ----------------
   task automatic do_reset();
      int cyc;
      int nreads;
      reset = 1'b1;
      cmd_valid = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      check("rst_busy", busy, 1);
      check("rst_done", done, 0);
      check("rst_irom_rd", IROM_rd, 0);
      check("rst_irom_a", IROM_A, 0);
      check("rst_iram_valid", IRAM_valid, 0);
      check("rst_iram_a", IRAM_A, 0);
      check("rst_iram_d", IRAM_D, 0);
      reset = 1'b0;
      cyc = 0;
      nreads = 0;
      while (busy !== 1'b0 && cyc < NPIX + 40) begin
         @(negedge clk);
         cyc++;
         if (IROM_rd === 1'b1) begin
            check("irom_addr", IROM_A, nreads);
            nreads++;
         end
      end
      check("load_reads", nreads, NPIX);
      check("load_in_time", 32'(cyc <= NPIX + 3), 1);
      check("irom_rd_after_load", IROM_rd, 0);
   endtask

   task automatic run_cmd(input int c);
      int n;
      cmd = 4'(c);
      cmd_valid = 1'b1;
      if (c == 0) begin
         for (int a = 0; a < NPIX; a++) sb.push_back('{1'b0, a, img[a]});
         sb.push_back('{1'b1, 0, 0});
      end else begin
         model_cmd(c);
      end
      @(negedge clk);
      cmd_valid = 1'b0;
      if (c != 0) begin
         check("exec_busy", busy, 1);
         @(negedge clk);
         check("exec_release", busy, 0);
      end else begin
         n = 0;
         while (busy === 1'b1 && n < NPIX + 20) begin
            n++;
            cmd_valid = 1'($urandom);
            cmd = 4'($urandom);
            @(negedge clk);
         end
         cmd_valid = 1'b0;
         check("write_busy_len", n, NPIX + 1);
         check("write_sb_drained", sb.size(), 0);
      end
   endtask

   task automatic reset_mid_write();
      int n;
      cmd = 4'h0;
      cmd_valid = 1'b1;
      for (int a = 0; a < 20; a++) sb.push_back('{1'b0, a, img[a]});
      @(negedge clk);
      cmd_valid = 1'b0;
      n = 0;
      while (!(IRAM_valid === 1'b1 && IRAM_A == AW'(19)) && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("write20_reached", IRAM_A, 19);
      reset = 1'b1;
      @(negedge clk);
      check("abort_valid", IRAM_valid, 0);
      check("abort_busy", busy, 1);
      check("abort_done", done, 0);
      check("abort_sb_empty", sb.size(), 0);
      do_reset();
   endtask

   task automatic identity_image();
      for (int a = 0; a < NPIX; a++) rom[a] = DATA_W'(a);
   endtask

   initial begin
      int seq_clamp [12] = '{1, 1, 1, 1, 1, 3, 3, 3, 3, 3, 7, 0};
      int c;
      identity_image();
      @(negedge clk);

      do_reset();                 // plain write-out of the identity image
      run_cmd(0);

      do_reset();                 // max over the centre window
      run_cmd(5);
      run_cmd(0);

      do_reset();                 // shifts saturate at (1,1), then average
      foreach (seq_clamp[i]) run_cmd(seq_clamp[i]);

      do_reset();                 // rotate CCW, write, rotate CW, write again
      run_cmd(8);
      run_cmd(0);
      run_cmd(9);
      run_cmd(0);

      c = IMG_W / 2;              // median window (no-op without the build option)
      rom[pidx(c-1, c-1)] = 8'd10;
      rom[pidx(c,   c-1)] = 8'd200;
      rom[pidx(c-1, c)]   = 8'd30;
      rom[pidx(c,   c)]   = 8'd40;
      do_reset();
      run_cmd(12);
      run_cmd(0);
      run_cmd(10);
      run_cmd(11);
      run_cmd(6);
      run_cmd(0);

      identity_image();           // reset at the 20th write, then a full write after reload
      do_reset();
      reset_mid_write();
      run_cmd(0);

      for (int r = 0; r < 4; r++) begin
         for (int a = 0; a < NPIX; a++) rom[a] = DATA_W'($urandom);
         do_reset();
         for (int k = 0; k < 16; k++) run_cmd($urandom_range(0, 15));
         run_cmd(0);
      end

      check("sb_final_empty", sb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish, compared %0d", compared);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/lcd_ctrl_gen2.md
LCD_CTRL_GEN2 -- requirements
Module: lcd_ctrl_gen2

Interface
REQ-001 SHALL provide parameter IMG_W, default 8, image side length in pixels (power of two, 4..64).
REQ-002 SHALL provide parameter DATA_W, default 8, pixel width in bits.
REQ-003 SHALL derive localparam AW = 2*log2(IMG_W), the pixel address width (6 at defaults).
REQ-004 SHALL have the following ports (clk first, reset second):
- clk  input  1  single clock, rising-edge
- reset  input  1  synchronous, active-high
- cmd  input  4  command code
- cmd_valid  input  1  cmd is presented
- IROM_rd  output  1  image ROM read enable
- IROM_A  output  AW  image ROM address
- IROM_Q  input  DATA_W  image ROM data
- IRAM_valid  output  1  result RAM write enable
- IRAM_D  output  DATA_W  result RAM write data
- IRAM_A  output  AW  result RAM write address
- busy  output  1  block not accepting commands
- done  output  1  write-out complete pulse
REQ-005 SHALL use one clock; reset is synchronous and active-high.

Function
REQ-006 SHALL, after reset release, read all IMG_W*IMG_W pixels from IROM in raster order (addr = row*IMG_W + col) into an internal buffer; IROM_Q for an address issued with IROM_rd=1 is valid at the second rising edge after issue.
REQ-007 SHALL hold busy=1 throughout load and drop busy within IMG_W*IMG_W+3 cycles of reset release; IROM_rd=0 after load.
REQ-008 SHALL accept a command only at a rising edge where busy=0 and cmd_valid=1; cmd is ignored otherwise.
REQ-009 SHALL assert busy on the cycle after acceptance; non-write commands complete in exactly one busy cycle.
REQ-010 SHALL keep operation point (X,Y), each in 1..IMG_W-1, reset to (IMG_W/2, IMG_W/2); window = pixels (X-1,Y-1) TL, (X,Y-1) TR, (X-1,Y) BL, (X,Y) BR.
REQ-011 SHALL decode: 0 write; 1 up (Y-1); 2 down (Y+1); 3 left (X-1); 4 right (X+1); 5 max; 6 min; 7 average; 8 rotate CCW; 9 rotate CW; A mirror X; B mirror Y; C median (REQ-020); others no-op.
REQ-012 SHALL saturate shifts: a shift that would leave 1..IMG_W-1 leaves (X,Y) unchanged.
REQ-013 SHALL write max/min of the four window pixels to all four positions.
REQ-014 SHALL compute average as floor(sum/4) with DATA_W+2-bit sum, no overflow, written to all four.
REQ-015 SHALL rotate CCW: TL<-TR, TR<-BR, BR<-BL, BL<-TL; CW is the inverse.
REQ-016 SHALL mirror X by swapping TL<->BL, TR<->BR; mirror Y by swapping TL<->TR, BL<->BR.
REQ-017 SHALL, on write, assert IRAM_valid for exactly IMG_W*IMG_W consecutive cycles with IRAM_A = 0,1,...,max and IRAM_D = buffer[IRAM_A], busy=1 throughout.
REQ-018 SHALL pulse done=1 for one cycle on the cycle after the last IRAM write, busy=1 in that cycle, busy=0 the cycle after; buffer and (X,Y) retained so further commands and repeat writes are legal.
REQ-019 SHALL treat a reserved code as a no-op with one busy cycle.

Configuration
REQ-020 SHALL, when macro LCD_CTRL_MEDIAN_EN is defined, implement cmd C as median: floor((second-smallest + second-largest)/2) written to all four pixels; without it cmd C is a reserved no-op and no sorting logic is compiled.

Reset
REQ-021 SHALL, while reset=1 at a rising edge, set busy=1, done=0, IROM_rd=0, IROM_A=0, IRAM_valid=0, IRAM_A=0, IRAM_D=0, (X,Y)=(IMG_W/2,IMG_W/2), FSM=LOAD.
REQ-022 SHALL, on reset during any operation (including mid-write), abort it, drop IRAM_valid next edge, and restart load after release.

Verification
REQ-023 Defaults, image pixel[a]=a, cmds 0 -> IRAM[a]=a for all 64, one done pulse, busy low after.
REQ-024 Same image, cmds 5,0 -> IRAM[27],[28],[35],[36] = 36 (0x24); others unchanged.
REQ-025 Same image, cmds 1,1,1,1,1,3,3,3,3,3,7,0 -> op point clamps at (1,1); IRAM[0],[1],[8],[9] = floor((0+1+8+9)/4)=4.
REQ-026 Same image, cmds 8,0 -> IRAM[27]=28, [28]=36, [36]=35, [35]=27; then 9,0 restores originals with second done.
REQ-027 With LCD_CTRL_MEDIAN_EN, window {10,200,30,40}, cmd C -> all four = 35; without macro -> unchanged, one busy cycle.
REQ-028 Reset asserted at 20th IRAM write -> IRAM_valid=0 next cycle, busy=1, reload, done not pulsed; IMG_W=16 build repeats REQ-023 with 256 writes.
